// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit, shift-add multiply and restoring divide, 33-cycle latency.
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle 64-bit multiplier (divides stay iterative).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opb_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic              busy_q;
  logic              ready_q;
  logic [XLEN-1:0]   result_q;

  logic              is_div_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_s;
  logic              div_zero_s, ovf_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic [XLEN:0]     sum_s, trial_s;

  // Apply the deferred sign and pick the product half, quotient or remainder.
  function automatic logic [XLEN-1:0] finish_res(input logic [2:0] op, input logic neg,
                                                 input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   x;
    if (op[2]) begin
      x = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      finish_res = neg ? -x : x;
    end else begin
      p = neg ? -acc : acc;
      finish_res = (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end
  endfunction

  // Operand signedness, magnitudes and single-cycle special cases.
  always_comb begin
    is_div_s = funct3[2];
    if (is_div_s) begin
      a_sgn_s = ~funct3[0];
      b_sgn_s = ~funct3[0];
    end else begin
      a_sgn_s = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      b_sgn_s = (funct3[1:0] == 2'b01);
    end
    a_neg_s = a_sgn_s & op_a[XLEN-1];
    b_neg_s = b_sgn_s & op_b[XLEN-1];
    if (a_neg_s) a_mag_s = -op_a;
    else         a_mag_s = op_a;
    if (b_neg_s) b_mag_s = -op_b;
    else         b_mag_s = op_b;
    if (is_div_s && funct3[1]) neg_s = a_neg_s;
    else                       neg_s = a_neg_s ^ b_neg_s;
    div_zero_s = is_div_s && (op_b == '0);
    ovf_s      = is_div_s && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  end

  // One datapath iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    sum_s   = '0;
    trial_s = '0;
    acc_d   = acc_q;
    if (op_q[2]) begin
      trial_s = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
      if (!trial_s[XLEN]) acc_d = {trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      if (acc_q[0]) sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
      else          sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]};
      acc_d = {sum_s, acc_q[XLEN-1:1]};
    end
  end

  // Control FSM with registered busy/ready/result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !kill) begin
            op_q  <= funct3;
            neg_q <= neg_s;
            cnt_q <= 5'd0;
            opb_q <= is_div_s ? b_mag_s : a_mag_s;
            acc_q <= {{XLEN{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
            if (div_zero_s) begin
              result_q <= funct3[1] ? op_a : '1;
              state_q  <= DONE;
              ready_q  <= 1'b1;
            end else if (ovf_s) begin
              result_q <= funct3[1] ? '0 : op_a;
              state_q  <= DONE;
              ready_q  <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div_s) begin
              result_q <= finish_res(funct3, neg_s,
                                     {{XLEN{1'b0}}, a_mag_s} * {{XLEN{1'b0}}, b_mag_s});
              state_q  <= DONE;
              ready_q  <= 1'b1;
`endif
            end else begin
              state_q <= BUSY;
              busy_q  <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (kill) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              result_q <= finish_res(op_q, neg_q, acc_d);
              state_q  <= DONE;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          // start is deliberately ignored so a held start cannot re-issue.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written held-start / kill / async-reset sequences.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        ready;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .ready(ready), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: RISC-V M semantics from plain 64-bit / native SV arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          qa, qb;
    logic        bz, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    qa = int'($signed(a));
    qb = int'($signed(b));
    bz = (b == 32'd0);
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p  = 64'd0;
    case (f)
      3'd0: begin p = sa * sb; model = p[31:0];  end
      3'd1: begin p = sa * sb; model = p[63:32]; end
      3'd2: begin p = sa * ub; model = p[63:32]; end
      3'd3: begin p = ua * ub; model = p[63:32]; end
      3'd4: model = bz ? 32'hFFFF_FFFF : (ov ? 32'h8000_0000 : 32'(qa / qb));
      3'd5: model = bz ? 32'hFFFF_FFFF : a / b;
      3'd6: model = bz ? a : (ov ? 32'd0 : 32'(qa % qb));
      3'd7: model = bz ? a : a % b;
      default: model = 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op with start held until ready; lat counts edges from the accepting edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat, output int bcnt);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    lat = 0; bcnt = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end while (!ready && lat < 100);
    r = result;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 100);
  endtask

  task automatic count_ready(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
  endtask

  vec_t        vecs[10];
  logic [31:0] r;
  int          lat, bcnt, n, pulses;
  logic [2:0]  rf;
  logic [31:0] ra, rb;

  initial begin
    vecs[0] = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[2] = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
    vecs[3] = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
    vecs[4] = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5] = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6] = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7] = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8] = '{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1};
    vecs[9] = '{3'd7, 32'd100,        32'd0,         32'd100,       1};

    rst = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    #12;
    check("reset_busy",   {31'd0, busy},  32'd0);
    check("reset_ready",  {31'd0, ready}, 32'd0);
    check("reset_result", result,         32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors, including the divide-by-zero fast path.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, r, lat, bcnt);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), (vecs[i].lat == 33) ? 32'd32 : 32'd0);
    end

    // Signed overflow for DIV and REM.
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bcnt);
    check("ovf_div_result", r, 32'h8000_0000);
    check("ovf_div_latency", 32'(lat), 32'd1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bcnt);
    check("ovf_rem_result", r, 32'd0);
    check("ovf_rem_latency", 32'(lat), 32'd1);

    // Randomized ops with biased divisors.
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(rf, ra, rb, r, lat, bcnt);
      check($sformatf("rand%0d_f%0d_result", i, rf), r, model(rf, ra, rb));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat(rf, ra, rb)));
    end

    // Start held across ready: one pulse, DONE ignores start, next op accepted from IDLE.
    @(negedge clk);
    funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    wait_ready(n);
    check("held_latency", 32'(n), 32'd33);
    check("held_result", result, 32'd14);
    @(posedge clk); #1;
    check("held_no_repeat_ready", {31'd0, ready}, 32'd0);
    check("held_no_repeat_busy",  {31'd0, busy},  32'd0);
    op_a = 32'd200;
    @(posedge clk); #1;
    check("held_accept_busy", {31'd0, busy}, 32'd1);
    wait_ready(n);
    check("held_second_latency", 32'(n), 32'd32);
    check("held_second_result", result, 32'd28);
    @(negedge clk);
    start = 1'b0;

    // Kill in the 10th BUSY cycle.
    @(negedge clk);
    funct3 = 3'd5; op_a = 32'd5000; op_b = 32'd3; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("kill_pre_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    check("kill_busy", {31'd0, busy},  32'd0);
    check("kill_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    count_ready(40, pulses);
    check("kill_no_ready", 32'(pulses), 32'd0);
    check("kill_result_hold", result, 32'd28);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    funct3 = 3'd3; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_ready",  {31'd0, ready}, 32'd0);
    check("rst_result", result,         32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    count_ready(40, pulses);
    check("rst_no_ready", 32'(pulses), 32'd0);

    // Unit still usable after reset.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, r, lat, bcnt);
    check("post_rst_result", r, 32'hFFFF_FFEB);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width in bits; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: EX-stage instruction is RV32M; held high while the instruction sits in EX.
REQ-005 The block SHALL have port kill, input, 1 bit: EX flush; aborts any operation.
REQ-006 The block SHALL have port funct3, input, 3 bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 The block SHALL have ports op_a and op_b, input, XLEN bits each: rs1 and rs2 values.
REQ-008 The block SHALL have port busy, output, 1 bit: operation in progress; consumed by hazard logic to stall ID.
REQ-009 The block SHALL have port ready, output, 1 bit: result valid this cycle; EX stall releases on it.
REQ-010 The block SHALL have port result, output, XLEN bits: registered result.

Function
REQ-011 The FSM SHALL use states IDLE, BUSY and DONE; busy = (state==BUSY); ready = (state==DONE); all outputs come from registers.
REQ-012 In IDLE with start=1 and kill=0, the block SHALL latch funct3, op_a and op_b and enter BUSY with a 5-bit iteration counter at 0.
REQ-013 In BUSY, the block SHALL perform one iteration per cycle (shift-add for multiply, restoring divide), enter DONE after the 32nd iteration, and write result on that transition.
REQ-014 Latency SHALL be 33 cycles from the start-sampling edge to ready=1; ready SHALL be high for exactly one cycle.
REQ-015 DONE SHALL always go to IDLE and SHALL ignore start, so a held start cannot re-issue the same instruction; back-to-back ops reach IDLE one cycle after ready, and the next start is accepted then.
REQ-016 Signed operands SHALL be converted to magnitude before iteration; sign SHALL be applied at completion (MULH: sign a^b; MULHSU: sign a only; quotient: sign a^b; remainder: sign of dividend).
REQ-017 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the 64-bit product.
REQ-018 Divide by zero SHALL go IDLE->DONE in 1 cycle: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL go IDLE->DONE in 1 cycle: DIV returns 0x80000000; REM returns 0.
REQ-020 kill SHALL have priority over start and iteration: next state IDLE, no ready pulse, result unchanged.
REQ-021 result SHALL hold its value until the next completion.

Reset
REQ-022 rst low SHALL force state IDLE, counter 0, busy 0, ready 0, result 0 and clear the operand/accumulator registers, regardless of clock.
REQ-023 Reset asserted mid-operation SHALL discard the operation; no ready pulse SHALL follow deassertion.

Configuration
REQ-024 With MULDIV_FAST_MUL_EN defined, the four multiply ops SHALL compute a full 64-bit product in one cycle and go IDLE->DONE (latency 1); divide ops are unchanged.
REQ-025 Without MULDIV_FAST_MUL_EN, multiply ops SHALL use the 33-cycle iterative path.

Verification
REQ-026 The bench SHALL check: MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB, ready exactly 33 cycles after start (1 with macro), busy high for 32 cycles.
REQ-027 The bench SHALL check: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-028 The bench SHALL check: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-029 The bench SHALL check: DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, ready one cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, ready one cycle after start.
REQ-030 The bench SHALL check: start held high across ready -> exactly one ready pulse, then new operands accepted from IDLE; kill in BUSY cycle 10 -> busy=0 next cycle, no ready, result unchanged.
REQ-031 The bench SHALL check: rst pulsed low mid-BUSY asynchronously -> busy, ready and result go to 0 immediately, and no ready pulse follows.
